// File: rtl/mux64_scan_ctrl.sv
// Scan controller for a downstream 64:1 mux: steps sel across a channel range,
// waits SETTLE cycles per channel, then captures mux_out into a 64-bit image.
module mux64_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  first_ch,
  input  logic [5:0]  last_ch,
  input  logic        mux_out,
  output logic [5:0]  sel,
  output logic        busy,
  output logic        done,
  output logic        sample_valid,
  output logic [5:0]  sample_ch,
  output logic [63:0] capture
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  logic [1:0]  state_reg;
  logic [3:0]  cnt_reg;
  logic [5:0]  last_reg;
  logic [63:0] capture_next;

  // Only the bit addressed by sel is loaded, and only in SAMPLE.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_cap
      assign capture_next[gi] = (state_reg == ST_SAMPLE && sel == 6'(gi)) ? mux_out
                                                                          : capture[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      last_reg     <= 6'd0;
      sel          <= 6'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= 6'd0;
      capture      <= 64'h0;
    end else begin
      done         <= 1'b0;
      sample_valid <= 1'b0;
      capture      <= capture_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            last_reg  <= last_ch;
            sel       <= first_ch;
            cnt_reg   <= 4'd0;
            busy      <= 1'b1;
            state_reg <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == CNT_LAST) state_reg <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          sample_ch    <= sel;
          sample_valid <= 1'b1;
          if (sel == last_reg) begin
            busy      <= 1'b0;
            state_reg <= ST_DONE;
          end else begin
            // 6-bit increment wraps 63 -> 0 for ranges with last < first.
            sel       <= sel + 6'd1;
            cnt_reg   <= 4'd0;
            state_reg <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux64_scan_ctrl.sv
// Directed bench for mux64_scan_ctrl: full, wrapped, single-channel, disturbed
// and reset-aborted scans against a behavioural 64:1 mux.
module tb_mux64_scan_ctrl;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  first_ch = 6'd0;
  logic [5:0]  last_ch = 6'd0;
  logic        mux_out;
  logic [5:0]  sel;
  logic        busy;
  logic        done;
  logic        sample_valid;
  logic [5:0]  sample_ch;
  logic [63:0] capture;
  logic [63:0] in_pat = 64'h0;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] IN1 = 64'hA5A5_0F0F_F0F0_5A5A;
  localparam logic [63:0] IN2 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] IN3 = 64'h0000_0000_0002_0000;
  localparam logic [63:0] IN4 = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;
  assign mux_out = in_pat[sel];

  mux64_scan_ctrl #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .first_ch(first_ch), .last_ch(last_ch),
    .mux_out(mux_out), .sel(sel), .busy(busy), .done(done),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .capture(capture)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, 64'(sel), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_sv"}, 64'(sample_valid), 64'd0);
    chk({tag, "_sch"}, 64'(sample_ch), 64'd0);
    chk({tag, "_cap"}, capture, 64'h0);
  endtask

  // Runs one scan, checking every cycle from the accepting edge to one past done.
  task automatic run_scan(input int first, input int last, input int n, input bit disturb);
    int total;
    int k;
    total = n * (S + 1) + 1;
    @(negedge clk);
    first_ch = 6'(first);
    last_ch  = 6'(last);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_accept", 64'(busy), 64'd1);
    for (int e = 1; e <= total; e++) begin
      @(posedge clk); #1;
      k = e / (S + 1);
      if (k > n - 1) k = n - 1;
      chk("sel", 64'(sel), 64'((first + k) % 64));
      chk("sample_valid", 64'(sample_valid),
          64'((e % (S + 1) == 0) && (e <= n * (S + 1))));
      if ((e % (S + 1) == 0) && (e <= n * (S + 1)))
        chk("sample_ch", 64'(sample_ch), 64'((first + e / (S + 1) - 1) % 64));
      chk("done", 64'(done), 64'(e == total));
      chk("busy", 64'(busy), 64'(e < n * (S + 1)));
      if (disturb && e < total) begin
        start    = e[0];
        first_ch = 6'($urandom);
        last_ch  = 6'($urandom);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_after", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk_zero("idle");
    end

    in_pat = IN1;
    run_scan(0, 63, 64, 1'b0);
    chk("cap_full", capture, IN1);

    in_pat = IN2;
    run_scan(60, 3, 8, 1'b0);
    chk("cap_wrap", capture, 64'h55A5_0F0F_F0F0_5A55);

    in_pat = IN3;
    run_scan(17, 17, 1, 1'b0);
    chk("sample_ch_single", 64'(sample_ch), 64'd17);
    chk("cap_single", capture, 64'h55A5_0F0F_F0F2_5A55);

    in_pat = IN4;
    run_scan(10, 20, 11, 1'b1);
    chk("cap_disturb", capture, 64'h55A5_0F0F_F0FF_FE55);

    // Abort during SETTLE of channel 5 (sel becomes 5 at edge 15).
    in_pat = IN1;
    @(negedge clk);
    first_ch = 6'd0;
    last_ch  = 6'd63;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      chk("abort_pre_done", 64'(done), 64'd0);
    end
    chk("abort_sel", 64'(sel), 64'd5);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_done", 64'(done), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
    end
    run_scan(0, 63, 64, 1'b0);
    chk("cap_after_rst", capture, IN1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
